// File: rtl/gamma_pkg.sv
// Shared types and helpers for the gamma-cycle sequencer.
// Holds the sequencer state encoding and the time-field width calculation.
package gamma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    REPORT
  } gamma_state_t;

  // Bits needed to count every aclk cycle of one gamma cycle.
  function automatic int time_width(input int gamma_cycle_width);
    return $clog2(gamma_cycle_width);
  endfunction

endpackage

// File: rtl/gamma_sequencer_if.sv
// Job, gate-drive and result signals between the gamma sequencer and its environment.
// slave is the sequencer's view, master is the job source / gate / result consumer.
interface gamma_sequencer_if #(
  parameter int TIME_W = 4
);

  logic              in_valid;
  logic              in_ready;
  logic [TIME_W-1:0] a_time;
  logic              a_en;
  logic [TIME_W-1:0] b_time;
  logic              b_en;
  logic              gate_rst;
  logic              a_pulse;
  logic              b_pulse;
  logic              y;
  logic              res_valid;
  logic              res_ready;
  logic [TIME_W-1:0] res_time;
  logic              res_fired;

  modport slave (
    input  in_valid, a_time, a_en, b_time, b_en, y, res_ready,
    output in_ready, gate_rst, a_pulse, b_pulse, res_valid, res_time, res_fired
  );

  modport master (
    output in_valid, a_time, a_en, b_time, b_en, y, res_ready,
    input  in_ready, gate_rst, a_pulse, b_pulse, res_valid, res_time, res_fired
  );

endinterface

// File: rtl/gamma_sequencer_spike_pulse_gen.sv
// Turns one operand spike time into a fixed-width pulse inside the RUN window.
// The pulse end is formed one bit wider than t, so a late spike truncates rather than wraps.
module spike_pulse_gen #(
  parameter int TIME_W      = 4,
  parameter int PULSE_WIDTH = 8
) (
  input  logic [TIME_W-1:0] t,
  input  logic              run,
  input  logic              en,
  input  logic [TIME_W-1:0] spike_time,
  output logic              pulse
);

  // Widths beyond one gamma cycle behave identically, so clamp to keep the sum in range.
  localparam int SPAN     = 1 << TIME_W;
  localparam int PW_CLAMP = (PULSE_WIDTH > SPAN) ? SPAN : PULSE_WIDTH;
  localparam logic [TIME_W:0] PW_EXT = (TIME_W+1)'(PW_CLAMP);

  logic [TIME_W:0] pulse_end;

  assign pulse_end = {1'b0, spike_time} + PW_EXT;
  assign pulse     = run && en && (t >= spike_time) && ({1'b0, t} < pulse_end);

endmodule

// File: rtl/gamma_sequencer.sv
// Gamma-cycle sequencer: accepts a two-operand spike job, drives the external temporal gate
// for one gamma cycle and reports the first rise time of the gate output.
module gamma_sequencer
  import gamma_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8
) (
  input  logic            aclk,
  input  logic            grst,
  gamma_sequencer_if.slave bus
);

  localparam int TIME_W = time_width(GAMMA_CYCLE_WIDTH);
  localparam logic [TIME_W-1:0] T_LAST = TIME_W'(GAMMA_CYCLE_WIDTH - 1);

  gamma_state_t      state_q;
  gamma_state_t      state_d;

  logic [TIME_W-1:0] a_time_q;
  logic              a_en_q;
  logic [TIME_W-1:0] b_time_q;
  logic              b_en_q;

  logic [TIME_W-1:0] t_q;
  logic              y_prev_q;
  logic [TIME_W-1:0] res_time_q;
  logic              res_fired_q;

  logic              in_ready;
  logic              gate_rst;
  logic              res_valid;
  logic              run;

  always_ff @(posedge aclk) begin
    if (grst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // grst also gates the outputs so nothing leaks out of an aborted job during the reset cycle.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    gate_rst  = grst;
    res_valid = 1'b0;
    run       = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        gate_rst = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        run = !grst;
        if (t_q == T_LAST) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        res_valid = !grst;
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (grst) begin
      a_time_q <= '0;
      a_en_q   <= 1'b0;
      b_time_q <= '0;
      b_en_q   <= 1'b0;
    end else if (state_q == IDLE && bus.in_valid) begin
      a_time_q <= bus.a_time;
      a_en_q   <= bus.a_en;
      b_time_q <= bus.b_time;
      b_en_q   <= bus.b_en;
    end
  end

  // Clearing y_prev in CLEAR makes a gate output already high at t==0 count as a rise.
  always_ff @(posedge aclk) begin
    if (grst) begin
      t_q         <= '0;
      y_prev_q    <= 1'b0;
      res_time_q  <= '0;
      res_fired_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          t_q         <= '0;
          y_prev_q    <= 1'b0;
          res_time_q  <= '0;
          res_fired_q <= 1'b0;
        end
        RUN: begin
          t_q      <= t_q + TIME_W'(1);
          y_prev_q <= bus.y;
          if (bus.y && !y_prev_q && !res_fired_q) begin
            res_time_q  <= t_q;
            res_fired_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  spike_pulse_gen #(
    .TIME_W      (TIME_W),
    .PULSE_WIDTH (PULSE_WIDTH)
  ) u_a_pulse (
    .t          (t_q),
    .run        (run),
    .en         (a_en_q),
    .spike_time (a_time_q),
    .pulse      (bus.a_pulse)
  );

  spike_pulse_gen #(
    .TIME_W      (TIME_W),
    .PULSE_WIDTH (PULSE_WIDTH)
  ) u_b_pulse (
    .t          (t_q),
    .run        (run),
    .en         (b_en_q),
    .spike_time (b_time_q),
    .pulse      (bus.b_pulse)
  );

  assign bus.in_ready  = in_ready;
  assign bus.gate_rst  = gate_rst;
  assign bus.res_valid = res_valid;
  assign bus.res_time  = res_fired_q ? res_time_q : '0;
  assign bus.res_fired = res_fired_q;

endmodule

// File: tb/tb_gamma_sequencer.sv
// Randomized self-checking bench for gamma_sequencer against a cycle-level behavioural model
// of pulse windows, first-rise detection, handshake timing and reset abort.
module tb_gamma_sequencer;

  localparam int GCW = 16;
  localparam int PW  = 8;
  localparam int TW  = $clog2(GCW);

  logic aclk;
  logic grst;
  logic xor_mode;
  logic y_drv;

  int assert_count;
  int fail_count;

  gamma_sequencer_if #(.TIME_W(TW)) bus ();

  gamma_sequencer #(
    .GAMMA_CYCLE_WIDTH (GCW),
    .PULSE_WIDTH       (PW)
  ) dut (
    .aclk (aclk),
    .grst (grst),
    .bus  (bus)
  );

  // Gate model: either a not-equal gate on the two pulses or a scripted waveform.
  assign bus.y = xor_mode ? (bus.a_pulse ^ bus.b_pulse) : y_drv;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic bit model_pulse(input int t, input int st, input bit en);
    return en && (t >= st) && (t < st + PW);
  endfunction

  // First 0->1 transition of the gate output within the gamma cycle, prior level taken as 0.
  function automatic void model_result(input logic [GCW-1:0] yseq, output bit fired,
                                       output int tm);
    bit prev;
    prev  = 1'b0;
    fired = 1'b0;
    tm    = 0;
    for (int t = 0; t < GCW; t++) begin
      if (!fired && yseq[t] && !prev) begin
        fired = 1'b1;
        tm    = t;
      end
      prev = yseq[t];
    end
  endfunction

  // Runs one complete job starting at a negedge with the DUT idle; ends at a negedge in IDLE.
  task automatic apply_stimulus(input int at, input bit ae, input int bt, input bit be,
                                input bit xm, input logic [GCW-1:0] ybits, input bit ycl,
                                input int hold);
    logic [GCW-1:0] yseq;
    bit fired;
    int tm;
    for (int t = 0; t < GCW; t++) begin
      yseq[t] = xm ? (model_pulse(t, at, ae) ^ model_pulse(t, bt, be)) : ybits[t];
    end
    model_result(yseq, fired, tm);

    check_output("idle_in_ready", bus.in_ready, 1);
    xor_mode      = xm;
    bus.in_valid  = 1'b1;
    bus.a_time    = TW'(at);
    bus.a_en      = ae;
    bus.b_time    = TW'(bt);
    bus.b_en      = be;
    bus.res_ready = 1'b0;

    @(negedge aclk);
    bus.in_valid = 1'b0;
    bus.a_time   = TW'($urandom);
    bus.a_en     = 1'($urandom);
    bus.b_time   = TW'($urandom);
    bus.b_en     = 1'($urandom);
    y_drv        = ycl;
    check_output("clear_gate_rst", bus.gate_rst, 1);
    check_output("clear_in_ready", bus.in_ready, 0);
    check_output("clear_a_pulse", bus.a_pulse, 0);
    check_output("clear_b_pulse", bus.b_pulse, 0);

    for (int k = 0; k < GCW; k++) begin
      @(negedge aclk);
      y_drv = ybits[k];
      check_output($sformatf("a_pulse_t%0d", k), bus.a_pulse, model_pulse(k, at, ae));
      check_output($sformatf("b_pulse_t%0d", k), bus.b_pulse, model_pulse(k, bt, be));
      check_output($sformatf("run_gate_rst_t%0d", k), bus.gate_rst, 0);
      check_output($sformatf("run_res_valid_t%0d", k), bus.res_valid, 0);
      check_output($sformatf("run_in_ready_t%0d", k), bus.in_ready, 0);
    end

    @(negedge aclk);
    y_drv = 1'($urandom);
    check_output("report_res_valid", bus.res_valid, 1);
    check_output("report_res_fired", bus.res_fired, fired);
    check_output("report_res_time", bus.res_time, tm);
    check_output("report_a_pulse", bus.a_pulse, 0);
    check_output("report_b_pulse", bus.b_pulse, 0);
    check_output("report_in_ready", bus.in_ready, 0);

    for (int h = 0; h < hold; h++) begin
      @(negedge aclk);
      check_output($sformatf("hold%0d_res_valid", h), bus.res_valid, 1);
      check_output($sformatf("hold%0d_res_time", h), bus.res_time, tm);
      check_output($sformatf("hold%0d_res_fired", h), bus.res_fired, fired);
      check_output($sformatf("hold%0d_in_ready", h), bus.in_ready, 0);
    end

    bus.res_ready = 1'b1;
    @(negedge aclk);
    bus.res_ready = 1'b0;
    check_output("post_in_ready", bus.in_ready, 1);
    check_output("post_res_valid", bus.res_valid, 0);
  endtask

  // Starts a job whose gate fires early, then aborts it with grst during t==6.
  task automatic apply_reset_abort();
    check_output("abort_idle_in_ready", bus.in_ready, 1);
    xor_mode     = 1'b0;
    y_drv        = 1'b1;
    bus.in_valid = 1'b1;
    bus.a_time   = TW'(2);
    bus.a_en     = 1'b1;
    bus.b_time   = TW'(0);
    bus.b_en     = 1'b0;
    @(negedge aclk);
    bus.in_valid = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge aclk);
    end
    check_output("abort_pre_a_pulse", bus.a_pulse, 1);
    grst = 1'b1;
    #1;
    check_output("abort_gate_rst", bus.gate_rst, 1);
    @(negedge aclk);
    y_drv = 1'b0;
    check_output("abort_res_valid", bus.res_valid, 0);
    check_output("abort_a_pulse", bus.a_pulse, 0);
    check_output("abort_b_pulse", bus.b_pulse, 0);
    check_output("abort_res_fired", bus.res_fired, 0);
    check_output("abort_res_time", bus.res_time, 0);
    grst = 1'b0;
    @(negedge aclk);
    check_output("abort_in_ready", bus.in_ready, 1);
    check_output("abort_post_gate_rst", bus.gate_rst, 0);
    check_output("abort_post_res_valid", bus.res_valid, 0);
  endtask

  initial begin
    assert_count  = 0;
    fail_count    = 0;
    grst          = 1'b1;
    xor_mode      = 1'b0;
    y_drv         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a_time    = '0;
    bus.a_en      = 1'b0;
    bus.b_time    = '0;
    bus.b_en      = 1'b0;
    bus.res_ready = 1'b0;

    repeat (3) @(negedge aclk);
    check_output("rst_gate_rst", bus.gate_rst, 1);
    check_output("rst_res_valid", bus.res_valid, 0);
    check_output("rst_a_pulse", bus.a_pulse, 0);
    check_output("rst_b_pulse", bus.b_pulse, 0);
    check_output("rst_res_fired", bus.res_fired, 0);
    check_output("rst_res_time", bus.res_time, 0);
    grst = 1'b0;
    @(negedge aclk);
    check_output("rst_in_ready", bus.in_ready, 1);
    check_output("rst_post_gate_rst", bus.gate_rst, 0);

    apply_stimulus(3, 1'b1, 3, 1'b1, 1'b1, '0, 1'b0, 0);
    apply_stimulus(2, 1'b1, 0, 1'b0, 1'b1, '0, 1'b0, 0);
    apply_stimulus(12, 1'b1, 0, 1'b0, 1'b1, '0, 1'b0, 0);
    apply_stimulus(5, 1'b1, 9, 1'b1, 1'b1, '0, 1'b0, 5);
    apply_stimulus(7, 1'b0, 1, 1'b0, 1'b0, '1, 1'b1, 0);
    apply_stimulus(15, 1'b0, 15, 1'b1, 1'b1, '0, 1'b0, 1);

    apply_reset_abort();
    apply_stimulus(4, 1'b1, 6, 1'b1, 1'b1, '0, 1'b0, 0);

    for (int j = 0; j < 30; j++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge aclk);
        check_output("gap_in_ready", bus.in_ready, 1);
        check_output("gap_res_valid", bus.res_valid, 0);
      end
      apply_stimulus($urandom_range(0, GCW - 1), 1'($urandom), $urandom_range(0, GCW - 1),
                     1'($urandom), 1'($urandom), GCW'($urandom & $urandom), 1'($urandom),
                     $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/gamma_sequencer.md
GAMMA_SEQUENCER -- requirements
Module: gamma_sequencer

Interface
REQ-001 The module SHALL have parameter GAMMA_CYCLE_WIDTH, default 16, meaning aclk cycles per gamma cycle; it SHALL be a power of two and at least 4.
REQ-002 The module SHALL have parameter PULSE_WIDTH, default 8, meaning aclk cycles per encoded input spike pulse; it SHALL be at least 1.
REQ-003 The module SHALL have local constant TIME_W = $clog2(GAMMA_CYCLE_WIDTH).
REQ-004 Port: aclk  input  1  sole clock; all logic is on the rising edge.
REQ-005 Port: grst  input  1  reset, synchronous, active-high.
REQ-006 Port: in_valid  input  1  a job (a_time, a_en, b_time, b_en) is offered.
REQ-007 Port: in_ready  output  1  a job is accepted on this cycle when in_valid is also high.
REQ-008 Port: a_time, b_time  input  TIME_W  spike time of each operand, in cycles from gamma start.
REQ-009 Port: a_en, b_en  input  1  operand spikes; 0 means null (no spike this gamma).
REQ-010 Port: gate_rst  output  1  reset pulse to the temporal gate latches.
REQ-011 Port: a_pulse, b_pulse  output  1  pulse-encoded operand drive to the gate.
REQ-012 Port: y  input  1  temporal gate output.
REQ-013 Port: res_valid  output  1  result is available.
REQ-014 Port: res_ready  input  1  consumer accepts the result.
REQ-015 Port: res_time  output  TIME_W  first-rise time of y.
REQ-016 Port: res_fired  output  1  y rose during the gamma cycle.

Function
REQ-017 The FSM SHALL have states IDLE, CLEAR, RUN and REPORT.
REQ-018 In IDLE, in_ready SHALL be 1 and in_ready SHALL be 0 in every other state; when in_valid && in_ready, the module SHALL latch all job fields and go to CLEAR.
REQ-019 In CLEAR, the module SHALL hold gate_rst=1 for exactly one cycle, clear the counter t, y_prev, res_fired and res_time, then go to RUN.
REQ-020 In RUN, t SHALL count 0..GAMMA_CYCLE_WIDTH-1, one value per cycle; at t==GAMMA_CYCLE_WIDTH-1 the next state SHALL be REPORT.
REQ-021 a_pulse SHALL be 1 only when state==RUN && a_en && a_time<=t<a_time+PULSE_WIDTH; the sum SHALL be computed in TIME_W+1 bits, with no wrap.
REQ-022 b_pulse SHALL be generated in the same way from b_time and b_en.
REQ-023 A pulse SHALL be truncated at the end of RUN and SHALL never extend into REPORT or the next gamma cycle.
REQ-024 In RUN, the module SHALL sample y every cycle; on the first cycle with y==1 && y_prev==0, res_time SHALL be set to t and res_fired to 1; later rises SHALL be ignored.
REQ-025 If y is already 1 at t==0, this SHALL count as a rise at time 0, because y_prev is cleared in CLEAR.
REQ-026 In REPORT, res_valid SHALL be 1, and res_time and res_fired SHALL be stable until res_valid && res_ready, after which the state SHALL be IDLE.
REQ-027 If res_fired==0 in REPORT, res_time SHALL read 0.
REQ-028 Latency: with acceptance on cycle 0, CLEAR SHALL be cycle 1, RUN cycles 2..GAMMA_CYCLE_WIDTH+1, and res_valid first high on cycle GAMMA_CYCLE_WIDTH+2.
REQ-029 When res_ready is held high, the job throughput SHALL be one job per GAMMA_CYCLE_WIDTH+3 cycles.
REQ-030 Outside CLEAR, gate_rst SHALL be 0; outside RUN, a_pulse and b_pulse SHALL be 0.

Reset
REQ-031 While grst is high at a clock edge, the module SHALL enter IDLE, clear t, y_prev, res_time and res_fired, and drive res_valid=0, a_pulse=0 and b_pulse=0.
REQ-032 gate_rst SHALL be 1 while grst is high so the gate latches are cleared together with the sequencer.
REQ-033 A grst asserted mid-RUN or mid-REPORT SHALL abort the job with no result, and in_ready SHALL be 1 on the first cycle after grst deasserts.

Structure
REQ-034 Package gamma_pkg SHALL hold the state enum (IDLE, CLEAR, RUN, REPORT) and a TIME_W helper function.
REQ-035 Sub-module spike_pulse_gen SHALL be instantiated once per operand, with inputs t, run, en and time, and output pulse.
REQ-036 The temporal gate (y source) SHALL be external to this module.

Verification
REQ-037 With GAMMA_CYCLE_WIDTH=16 and PULSE_WIDTH=8: job a_time=3, b_time=3, both enabled -> a_pulse and b_pulse high for t=3..10, res_fired=0 with a not_equal gate model.
REQ-038 Job a_time=2, a_en=1, b_en=0 -> a_pulse high for t=2..9, y rises at t=2, res_time=2, res_fired=1, res_valid on cycle 18 after acceptance.
REQ-039 Job a_time=12 -> a_pulse high for t=12..15 only, with no pulse in REPORT.
REQ-040 With res_ready held low for 5 cycles in REPORT -> res_valid and res_time stable and in_ready=0 throughout; in_ready=1 on the cycle after the res_ready handshake.
REQ-041 With grst pulsed at t=6 of RUN -> outputs zero, no res_valid, and the next job completes normally.
REQ-042 With y forced high from CLEAR onward -> res_time=0, res_fired=1.
